// File: rtl/udma_filter_pkg.sv
// rtl/udma_filter_pkg.sv - shared mode/state constants and stride helper for the uDMA filter engines
package udma_filter_pkg;

   localparam logic [1:0] MODE_LINEAR = 2'd0;
   localparam logic [1:0] MODE_2D_ROW = 2'd1;
   localparam logic [1:0] MODE_2D_COL = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } udma_state_e;

   // Element size in bytes; the reserved encoding advances by nothing.
   function automatic logic [2:0] stride_bytes(input logic [1:0] datasize);
      case (datasize)
         2'd0:    return 3'd1;
         2'd1:    return 3'd2;
         2'd2:    return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/udma_filter_tx_datafetch_if.sv
// rtl/udma_filter_tx_datafetch_if.sv - TX channel read bus plus outgoing data stream
interface udma_filter_tx_datafetch_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int L2_AWIDTH_NOAL = 15
) ();

   logic                      tx_ch_req;
   logic [L2_AWIDTH_NOAL-1:0] tx_ch_addr;
   logic [1:0]                tx_ch_datasize;
   logic                      tx_ch_gnt;
   logic                      tx_ch_valid;
   logic [DATA_WIDTH-1:0]     tx_ch_data;
   logic                      tx_ch_ready;

   logic [DATA_WIDTH-1:0]     stream_data;
   logic                      stream_valid;
   logic                      stream_ready;

   // Fetch engine side: issues reads, produces the stream.
   modport master (
      output tx_ch_req, tx_ch_addr, tx_ch_datasize, tx_ch_ready,
      output stream_data, stream_valid,
      input  tx_ch_gnt, tx_ch_valid, tx_ch_data,
      input  stream_ready
   );

   // L2 / consumer side.
   modport slave (
      input  tx_ch_req, tx_ch_addr, tx_ch_datasize, tx_ch_ready,
      input  stream_data, stream_valid,
      output tx_ch_gnt, tx_ch_valid, tx_ch_data,
      output stream_ready
   );

endinterface

// File: rtl/io_generic_fifo.sv
// rtl/io_generic_fifo.sv - small circular FIFO with occupancy output
module io_generic_fifo #(
   parameter int DATA_WIDTH   = 32,
   parameter int BUFFER_DEPTH = 4
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   output logic [$clog2(BUFFER_DEPTH+1)-1:0]     elements_o,
   output logic [DATA_WIDTH-1:0]                 data_o,
   output logic                                  valid_o,
   input  logic                                  ready_i,
   input  logic                                  valid_i,
   input  logic [DATA_WIDTH-1:0]                 data_i,
   output logic                                  ready_o
);

   localparam int CW = $clog2(BUFFER_DEPTH + 1);
   localparam int PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;

   logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  push, pop;

   assign valid_o    = (cnt_q != '0);
   assign ready_o    = (cnt_q < CW'(BUFFER_DEPTH));
   assign push       = valid_i && ready_o;
   assign pop        = valid_o && ready_i;
   assign data_o     = mem_q[rd_ptr_q];
   assign elements_o = cnt_q;

   // Pointer wrap and occupancy bookkeeping.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) wr_ptr_d = (wr_ptr_q == PW'(BUFFER_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == PW'(BUFFER_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: occupancy gates every read.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/udma_filter_tx_datafetch.sv
// rtl/udma_filter_tx_datafetch.sv - credit-limited L2 read engine feeding the filter stream
module udma_filter_tx_datafetch
   import udma_filter_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int L2_AWIDTH_NOAL = 15,
   parameter int BUFFER_DEPTH   = 4,
   parameter int TRANS_SIZE     = 16
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   udma_filter_tx_datafetch_if.master bus_if,
   input  logic                      cmd_start_i,
   output logic                      cmd_done_o,
   input  logic [L2_AWIDTH_NOAL-1:0] cfg_start_addr_i,
   input  logic [1:0]                cfg_datasize_i,
   input  logic [1:0]                cfg_mode_i,
   input  logic [TRANS_SIZE-1:0]     cfg_len0_i,
   input  logic [TRANS_SIZE-1:0]     cfg_len1_i,
   input  logic [TRANS_SIZE-1:0]     cfg_len2_i
);

   localparam int AW = L2_AWIDTH_NOAL;
   localparam int CW = $clog2(BUFFER_DEPTH + 1);

   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_RUN   = ST_RUN;
   localparam logic [1:0] S_DRAIN = ST_DRAIN;

   logic [1:0]            state_q, state_d;
   logic [1:0]            mode_q, mode_d;
   logic [AW-1:0]         ptr_q, ptr_d;
   logic [AW-1:0]         base_q, base_d;
   logic [TRANS_SIZE-1:0] cnt_w_q, cnt_w_d;
   logic [TRANS_SIZE-1:0] cnt_l_q, cnt_l_d;
   logic [CW-1:0]         outst_q, outst_d;
   logic                  done_q, done_d;

   logic [CW-1:0]         fifo_elems;
   logic [CW:0]           in_flight;
   logic                  tx_req, fire;
   logic                  last_w, last_l, is_2d, is_last;
   logic [AW-1:0]         stride, len2_aw;

   // Credit covers both reads in flight and words parked in the FIFO, so
   // every returning word is guaranteed a slot.
   assign in_flight = {1'b0, outst_q} + {1'b0, fifo_elems};
   assign tx_req    = (state_q == S_RUN) && (in_flight < (CW+1)'(BUFFER_DEPTH));
   assign fire      = tx_req && bus_if.tx_ch_gnt;

   assign stride  = AW'(stride_bytes(cfg_datasize_i));
   assign len2_aw = AW'(cfg_len2_i);
   assign last_w  = (cnt_w_q == cfg_len0_i);
   assign last_l  = (cnt_l_q == cfg_len1_i);
   assign is_2d   = (mode_q == MODE_2D_ROW) || (mode_q == MODE_2D_COL);
   assign is_last = is_2d ? (last_w && last_l) : last_w;

   assign bus_if.tx_ch_req      = tx_req;
   assign bus_if.tx_ch_addr     = ptr_q;
   assign bus_if.tx_ch_datasize = cfg_datasize_i;
   assign cmd_done_o            = done_q;

   // FSM and address pattern generator; addresses move only on a granted request.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      ptr_d   = ptr_q;
      base_d  = base_q;
      cnt_w_d = cnt_w_q;
      cnt_l_d = cnt_l_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_start_i) begin
               state_d = S_RUN;
               mode_d  = cfg_mode_i;
               ptr_d   = cfg_start_addr_i;
               base_d  = cfg_start_addr_i;
               cnt_w_d = '0;
               cnt_l_d = '0;
            end
         end
         S_RUN: begin
            if (fire) begin
               if (is_last) begin
                  state_d = S_DRAIN;
               end else begin
                  case (mode_q)
                     MODE_2D_ROW: begin
                        if (last_w) begin
                           cnt_w_d = '0;
                           cnt_l_d = cnt_l_q + TRANS_SIZE'(1);
                           base_d  = base_q + len2_aw;
                           ptr_d   = base_q + len2_aw;
                        end else begin
                           cnt_w_d = cnt_w_q + TRANS_SIZE'(1);
                           ptr_d   = ptr_q + stride;
                        end
                     end
                     MODE_2D_COL: begin
                        if (last_l) begin
                           cnt_l_d = '0;
                           cnt_w_d = cnt_w_q + TRANS_SIZE'(1);
                           base_d  = base_q + stride;
                           ptr_d   = base_q + stride;
                        end else begin
                           cnt_l_d = cnt_l_q + TRANS_SIZE'(1);
                           ptr_d   = ptr_q + len2_aw;
                        end
                     end
                     default: begin
                        cnt_w_d = cnt_w_q + TRANS_SIZE'(1);
                        ptr_d   = ptr_q + stride;
                     end
                  endcase
               end
            end
         end
         S_DRAIN: begin
            if ((outst_q == '0) && (fifo_elems == '0)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Reads in flight: grant adds one, returned data removes one.
   always_comb begin
      case ({fire, bus_if.tx_ch_valid})
         2'b10:   outst_d = outst_q + CW'(1);
         2'b01:   outst_d = outst_q - CW'(1);
         default: outst_d = outst_q;
      endcase
   end

   // Engine state registers; reset aborts any transfer silently.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         mode_q  <= MODE_LINEAR;
         ptr_q   <= '0;
         base_q  <= '0;
         cnt_w_q <= '0;
         cnt_l_q <= '0;
         outst_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         ptr_q   <= ptr_d;
         base_q  <= base_d;
         cnt_w_q <= cnt_w_d;
         cnt_l_q <= cnt_l_d;
         outst_q <= outst_d;
         done_q  <= done_d;
      end
   end

   io_generic_fifo #(
      .DATA_WIDTH   (DATA_WIDTH),
      .BUFFER_DEPTH (BUFFER_DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (reset_i),
      .elements_o (fifo_elems),
      .data_o     (bus_if.stream_data),
      .valid_o    (bus_if.stream_valid),
      .ready_i    (bus_if.stream_ready),
      .valid_i    (bus_if.tx_ch_valid),
      .data_i     (bus_if.tx_ch_data),
      .ready_o    (bus_if.tx_ch_ready)
   );

   // Returned data must always find room; anything else is an L2 protocol error.
   a_no_refused_data: assert property (@(posedge clk_i) disable iff (reset_i)
      bus_if.tx_ch_valid |-> bus_if.tx_ch_ready);

endmodule

// File: tb/tb_udma_filter_tx_datafetch.sv
// tb/tb_udma_filter_tx_datafetch.sv - directed self-checking bench for the TX data fetch engine
module tb_udma_filter_tx_datafetch;

   localparam int DW = 32;
   localparam int AW = 15;
   localparam int BD = 4;
   localparam int TS = 16;

   logic          clk = 1'b0;
   logic          reset_i = 1'b1;
   logic          cmd_start;
   logic          cmd_done;
   logic [AW-1:0] cfg_start_addr;
   logic [1:0]    cfg_datasize;
   logic [1:0]    cfg_mode;
   logic [TS-1:0] cfg_len0, cfg_len1, cfg_len2;

   int            n_cmp = 0;
   int            n_err = 0;
   int            cyc = 0;
   int            done_cnt = 0;
   int            proto_err = 0;
   int            first_txv = -1;
   int            first_sv = -1;
   bit            l2_hold = 1'b0;

   logic [AW-1:0] addr_log [$];
   logic [AW-1:0] pend_q [$];
   logic [AW-1:0] exp_q [$];
   logic [DW-1:0] strm_log [$];

   always #5 clk = ~clk;

   udma_filter_tx_datafetch_if #(.DATA_WIDTH(DW), .L2_AWIDTH_NOAL(AW)) bus ();

   udma_filter_tx_datafetch #(
      .DATA_WIDTH(DW), .L2_AWIDTH_NOAL(AW), .BUFFER_DEPTH(BD), .TRANS_SIZE(TS)
   ) dut (
      .clk_i            (clk),
      .reset_i          (reset_i),
      .bus_if           (bus),
      .cmd_start_i      (cmd_start),
      .cmd_done_o       (cmd_done),
      .cfg_start_addr_i (cfg_start_addr),
      .cfg_datasize_i   (cfg_datasize),
      .cfg_mode_i       (cfg_mode),
      .cfg_len0_i       (cfg_len0),
      .cfg_len1_i       (cfg_len1),
      .cfg_len2_i       (cfg_len2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: samples on the falling edge, well away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (cmd_done) done_cnt++;
         if (!reset_i) begin
            if (bus.tx_ch_valid && !bus.tx_ch_ready) proto_err++;
            if (bus.tx_ch_req && bus.tx_ch_gnt) begin
               addr_log.push_back(bus.tx_ch_addr);
               pend_q.push_back(bus.tx_ch_addr);
            end
            if (bus.tx_ch_valid && first_txv < 0) first_txv = cyc;
            if (bus.stream_valid && first_sv < 0) first_sv = cyc;
            if (bus.stream_valid && bus.stream_ready) strm_log.push_back(bus.stream_data);
         end
      end
   end

   // L2 model: data for a granted read appears the cycle after the grant.
   initial begin
      logic [AW-1:0] a;
      bus.tx_ch_valid = 1'b0;
      bus.tx_ch_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (!l2_hold && !reset_i && pend_q.size() > 0) begin
            a = pend_q.pop_front();
            bus.tx_ch_valid = 1'b1;
            bus.tx_ch_data  = 32'hD000_0000 | {17'b0, a};
         end else begin
            bus.tx_ch_valid = 1'b0;
         end
      end
   end

   task automatic start_run(input logic [AW-1:0] addr, input logic [1:0] ds, input logic [1:0] mode,
                            input logic [TS-1:0] l0, input logic [TS-1:0] l1, input logic [TS-1:0] l2);
      addr_log.delete();
      strm_log.delete();
      exp_q.delete();
      done_cnt  = 0;
      first_txv = -1;
      first_sv  = -1;
      cfg_start_addr = addr;
      cfg_datasize   = ds;
      cfg_mode       = mode;
      cfg_len0       = l0;
      cfg_len1       = l1;
      cfg_len2       = l2;
      cmd_start      = 1'b1;
      tick(1);
      cmd_start      = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k;
      k = 0;
      while (done_cnt == 0 && k < budget) begin
         tick(1);
         k++;
      end
      check({tag, " done seen"}, 32'(done_cnt > 0), 32'd1);
      tick(3);
      check({tag, " done pulses"}, done_cnt, 32'd1);
   endtask

   task automatic verify(input string tag);
      logic [31:0] got;
      check({tag, " n_addr"}, addr_log.size(), exp_q.size());
      check({tag, " n_beats"}, strm_log.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < addr_log.size()) ? 32'(addr_log[i]) : 32'hFFFF_FFFF;
         check($sformatf("%s addr[%0d]", tag, i), got, 32'(exp_q[i]));
         got = (i < strm_log.size()) ? strm_log[i] : 32'hFFFF_FFFF;
         check($sformatf("%s data[%0d]", tag, i), got, 32'hD000_0000 | {17'b0, exp_q[i]});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000ns");
      $fatal(1);
   end

   initial begin
      cmd_start = 1'b0;
      cfg_start_addr = '0;
      cfg_datasize = '0;
      cfg_mode = '0;
      cfg_len0 = '0;
      cfg_len1 = '0;
      cfg_len2 = '0;
      bus.tx_ch_gnt    = 1'b1;
      bus.stream_ready = 1'b1;

      tick(2);
      check("rst req", bus.tx_ch_req, 0);
      check("rst addr", bus.tx_ch_addr, 0);
      check("rst done", cmd_done, 0);
      check("rst svalid", bus.stream_valid, 0);
      reset_i = 1'b0;
      tick(2);

      // 1: linear word fetch
      start_run(15'h100, 2'd2, 2'd0, 16'd3, 16'd0, 16'd0);
      wait_done("t1", 100);
      exp_q = '{15'h100, 15'h104, 15'h108, 15'h10C};
      verify("t1");
      check("t1 latency", first_sv - first_txv, 1);

      // 2: 2D row, byte elements
      start_run(15'h0, 2'd0, 2'd1, 16'd1, 16'd2, 16'h10);
      wait_done("t2", 100);
      exp_q = '{15'h0, 15'h1, 15'h10, 15'h11, 15'h20, 15'h21};
      verify("t2");

      // 3: 2D col, half-word elements
      start_run(15'h0, 2'd1, 2'd2, 16'd1, 16'd2, 16'h20);
      wait_done("t3", 100);
      exp_q = '{15'h0, 15'h20, 15'h40, 15'h2, 15'h22, 15'h42};
      verify("t3");

      // 4: consumer stalled, credit limits outstanding work to the FIFO depth
      bus.stream_ready = 1'b0;
      start_run(15'h200, 2'd2, 2'd0, 16'd9, 16'd0, 16'd0);
      tick(20);
      check("t4 grants stalled", addr_log.size(), 4);
      check("t4 req stalled", bus.tx_ch_req, 0);
      check("t4 svalid stalled", bus.stream_valid, 1);
      bus.stream_ready = 1'b1;
      wait_done("t4", 200);
      for (int i = 0; i < 10; i++) exp_q.push_back(15'h200 + 15'(4 * i));
      verify("t4");
      check("t4 protocol", proto_err, 0);

      // 5: grant withheld on the 2nd request, stray start ignored
      start_run(15'h40, 2'd2, 2'd0, 16'd3, 16'd0, 16'd0);
      for (int k = 0; k < 20 && addr_log.size() < 1; k++) tick(1);
      bus.tx_ch_gnt = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("t5 req hold%0d", k), bus.tx_ch_req, 1);
         check($sformatf("t5 addr hold%0d", k), bus.tx_ch_addr, 15'h44);
         cmd_start = (k == 1);
         cfg_start_addr = (k == 1) ? 15'h7000 : 15'h40;
         tick(1);
      end
      cmd_start = 1'b0;
      cfg_start_addr = 15'h40;
      check("t5 addr hold3", bus.tx_ch_addr, 15'h44);
      check("t5 grants held", addr_log.size(), 1);
      bus.tx_ch_gnt = 1'b1;
      wait_done("t5", 100);
      exp_q = '{15'h40, 15'h44, 15'h48, 15'h4C};
      verify("t5");

      // 6: reset in DRAIN with two reads outstanding, then an address wrap run
      l2_hold = 1'b1;
      start_run(15'h300, 2'd2, 2'd0, 16'd1, 16'd0, 16'd0);
      tick(6);
      check("t6 grants", addr_log.size(), 2);
      check("t6 req drain", bus.tx_ch_req, 0);
      reset_i = 1'b1;
      #1;
      pend_q.delete();
      check("t6 rst req", bus.tx_ch_req, 0);
      check("t6 rst addr", bus.tx_ch_addr, 0);
      check("t6 rst done", cmd_done, 0);
      check("t6 rst svalid", bus.stream_valid, 0);
      tick(2);
      reset_i = 1'b0;
      l2_hold = 1'b0;
      tick(5);
      check("t6 no done", done_cnt, 0);
      start_run(15'h7FFC, 2'd2, 2'd0, 16'd1, 16'd0, 16'd0);
      wait_done("t6w", 100);
      exp_q = '{15'h7FFC, 15'h0000};
      verify("t6w");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
